multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle control FSM for the CPU datapath. It supersedes the fixed-latency partial control unit and adds four capabilities:
- a configurable memory read latency;
- full decode for add/and/sub/addi;
- overflow and invalid-opcode exceptions with a cause register;
- a debug state output.

It drives every datapath mux and write-enable from a Moore state decode.

## Interface
- MEM_WAIT, 1 — memory read latency in wait cycles, legal 1..15.
- OVF_EN, 1 — 1: overflow traps on add/sub/addi; 0: overflow ignored, result written.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- OpCode  in  6  IR[31:26]
- Func  in  6  IR[5:0]
- Overflow  in  1  ALU overflow, combinational, valid in execute states
- SrcAddressMem  out  3  memory address mux: 0 PC, 3 vector 253, 4 vector 254
- MemOp  out  1  0 read; always 0 in this block
- WriteMDR, IRWrite, RegWrite, WriteA, WriteB, WriteALUOut, EPCWrite, PCWrite  out  1 each  write enables
- RegDst  out  3  0 rt, 1 rd, 3 reg 29
- ALUSrcA  out  2  0 PC, 1 A
- ALUSrcB  out  3  0 B, 1 const 4, 2 sign-ext imm, 3 imm<<2
- ALUOp  out  3  1 add, 2 sub, 3 and
- PCSource  out  2  0 ALU result, 1 MDR zero-extended
- MemToReg  out  3  0 ALUOut, 7 const 227
- ExcCause  out  2  0 none, 1 invalid opcode, 2 overflow
- StateOut  out  4  current state code

## Operation
- Outputs are a pure decode of the state register. Any signal not listed for a state is 0.
- State codes and output values:
  - RST=0: RegDst=3, MemToReg=7, RegWrite=1.
  - FETCH=1: ALUSrcB=1, ALUOp=1, PCWrite=1.
  - MWAIT=2: all outputs 0.
  - IRLD=3: IRWrite=1.
  - DECODE=4: WriteA=WriteB=1, ALUSrcB=3, ALUOp=1, WriteALUOut=1.
  - ADD=5: ALUSrcA=1, ALUOp=1, WriteALUOut=1.
  - AND=6: ALUSrcA=1, ALUOp=3, WriteALUOut=1.
  - SUB=7: ALUSrcA=1, ALUOp=2, WriteALUOut=1.
  - ADDI=8: ALUSrcA=1, ALUSrcB=2, ALUOp=1, WriteALUOut=1.
  - WRRD=9: RegDst=1, RegWrite=1.
  - WRRT=10: RegDst=0, RegWrite=1.
  - EXC=11: ALUSrcB=1, ALUOp=2, EPCWrite=1, SrcAddressMem=vec.
  - EWAIT=12: SrcAddressMem=vec.
  - ELD=13: SrcAddressMem=vec, WriteMDR=1.
  - EJMP=14: PCSource=1, PCWrite=1.
- vec: 3 when ExcCause=1, 4 when ExcCause=2.
- Transitions:
  - RST→FETCH, FETCH→MWAIT.
  - MWAIT holds for exactly MEM_WAIT cycles, then →IRLD.
  - IRLD→DECODE.
  - DECODE branches on instruction:
    - OpCode=0, Func=0x20 → ADD.
    - OpCode=0, Func=0x24 → AND.
    - OpCode=0, Func=0x22 → SUB.
    - OpCode=0x08 → ADDI.
    - anything else → EXC, with ExcCause←1.
  - ADD/SUB: →EXC with ExcCause←2 when Overflow & OVF_EN, else →WRRD.
  - ADDI: same overflow rule, else →WRRT.
  - AND: always →WRRD; overflow is not sampled.
  - WRRD/WRRT→FETCH.
  - EXC→EWAIT. EWAIT holds for MEM_WAIT cycles, then →ELD→EJMP→FETCH.
- Wait counter: 4-bit, loaded with MEM_WAIT-1 on entry to MWAIT or EWAIT, decremented each cycle; the state exits when the counter reads 0.
- ExcCause changes only on entry to EXC. It holds its value through later instructions until the next exception or reset.
- Overflow is ignored outside states ADD, SUB and ADDI.

## Timing
- Reset is asynchronous: on reset=0 the state goes immediately to RST, the counter to 0, ExcCause to 0.
  - Outputs during and after reset are the RST decode: RegDst=3, MemToReg=7, RegWrite=1, all else 0, StateOut=0.
- Reset asserted mid-instruction or mid-exception aborts the sequence. No partial write follows; the first state after release is FETCH, one edge after RST.
- Instruction latency in cycles, first FETCH to next FETCH:
  - add/sub/and/addi: MEM_WAIT+5.
  - invalid opcode: MEM_WAIT+3+(MEM_WAIT+3).
  - overflow trap: MEM_WAIT+4+(MEM_WAIT+3).
- Register writes (RegWrite, PCWrite, EPCWrite, IRWrite, WriteMDR) are single-cycle pulses. No enable is held across consecutive states except SrcAddressMem through EXC, EWAIT and ELD.
- MEM_WAIT=1 is the minimum: MWAIT lasts one cycle.

## Test plan
- Reset held low for 3 cycles, then released:
  - during reset, StateOut=0, RegWrite=1, RegDst=3, MemToReg=7;
  - StateOut sequence after release is 1,2,3,4.
- MEM_WAIT=4, add ($0 funct 0x20), Overflow=0:
  - StateOut 1,2,2,2,2,3,4,5,9,1 (9 cycles);
  - RegWrite=1 with RegDst=1 only in state 9.
- addi (0x08) with Overflow=1 in state 8, OVF_EN=1:
  - →11 with ExcCause=2 and EPCWrite=1;
  - SrcAddressMem=4 through states 11,12,13;
  - state 14 has PCSource=1 and PCWrite=1, then FETCH.
- Same stimulus with OVF_EN=0: →10 (WRRT), RegWrite=1, RegDst=0, ExcCause stays 0.
- OpCode=0x3F: DECODE→11 with ExcCause=1 and SrcAddressMem=3; a following valid add leaves ExcCause=1.
- reset pulsed low during EWAIT: immediate StateOut=0, ExcCause=0, no PCWrite pulse; after release, FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/status inputs and datapath control outputs of multicycle_ctrl
interface multicycle_ctrl_if;
   logic [5:0] OpCode;
   logic [5:0] Func;
   logic       Overflow;
   logic [2:0] SrcAddressMem;
   logic       MemOp;
   logic       WriteMDR;
   logic       IRWrite;
   logic       RegWrite;
   logic       WriteA;
   logic       WriteB;
   logic       WriteALUOut;
   logic       EPCWrite;
   logic       PCWrite;
   logic [2:0] RegDst;
   logic [1:0] ALUSrcA;
   logic [2:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic [1:0] PCSource;
   logic [2:0] MemToReg;
   logic [1:0] ExcCause;
   logic [3:0] StateOut;

   modport master (
      output OpCode, Func, Overflow,
      input  SrcAddressMem, MemOp, WriteMDR, IRWrite, RegWrite, WriteA, WriteB,
             WriteALUOut, EPCWrite, PCWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, MemToReg, ExcCause, StateOut
   );

   modport slave (
      input  OpCode, Func, Overflow,
      output SrcAddressMem, MemOp, WriteMDR, IRWrite, RegWrite, WriteA, WriteB,
             WriteALUOut, EPCWrite, PCWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
             PCSource, MemToReg, ExcCause, StateOut
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with wait-state memory reads and exceptions
module multicycle_ctrl #(
   parameter int MEM_WAIT = 1,
   parameter bit OVF_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.slave  bus
);
   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_MWAIT  = 4'd2,
      S_IRLD   = 4'd3,
      S_DECODE = 4'd4,
      S_ADD    = 4'd5,
      S_AND    = 4'd6,
      S_SUB    = 4'd7,
      S_ADDI   = 4'd8,
      S_WRRD   = 4'd9,
      S_WRRT   = 4'd10,
      S_EXC    = 4'd11,
      S_EWAIT  = 4'd12,
      S_ELD    = 4'd13,
      S_EJMP   = 4'd14
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] cause_q, cause_d;
   logic [2:0] vec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RST;
         cnt_q   <= 4'd0;
         cause_q <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         S_RST:   state_d = S_FETCH;
         S_FETCH: begin
            state_d = S_MWAIT;
            cnt_d   = WAIT_LOAD;
         end
         S_MWAIT: begin
            if (cnt_q == 4'd0) state_d = S_IRLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_IRLD:  state_d = S_DECODE;
         S_DECODE: begin
            if (bus.OpCode == 6'h00 && bus.Func == 6'h20)      state_d = S_ADD;
            else if (bus.OpCode == 6'h00 && bus.Func == 6'h24) state_d = S_AND;
            else if (bus.OpCode == 6'h00 && bus.Func == 6'h22) state_d = S_SUB;
            else if (bus.OpCode == 6'h08)                      state_d = S_ADDI;
            else begin
               state_d = S_EXC;
               cause_d = 2'd1;
            end
         end
         S_ADD, S_SUB, S_ADDI: begin
            if (bus.Overflow && OVF_EN) begin
               state_d = S_EXC;
               cause_d = 2'd2;
            end else begin
               state_d = (state_q == S_ADDI) ? S_WRRT : S_WRRD;
            end
         end
         S_AND:           state_d = S_WRRD;
         S_WRRD, S_WRRT:  state_d = S_FETCH;
         S_EXC: begin
            state_d = S_EWAIT;
            cnt_d   = WAIT_LOAD;
         end
         S_EWAIT: begin
            if (cnt_q == 4'd0) state_d = S_ELD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ELD:   state_d = S_EJMP;
         S_EJMP:  state_d = S_FETCH;
         default: state_d = S_RST;
      endcase
   end

   // Exception vector address selector: 253 for invalid opcode, 254 for overflow
   assign vec = (cause_q == 2'd2) ? 3'd4 : 3'd3;

   always_comb begin
      bus.SrcAddressMem = 3'd0;
      bus.MemOp         = 1'b0;
      bus.WriteMDR      = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.WriteA        = 1'b0;
      bus.WriteB        = 1'b0;
      bus.WriteALUOut   = 1'b0;
      bus.EPCWrite      = 1'b0;
      bus.PCWrite       = 1'b0;
      bus.RegDst        = 3'd0;
      bus.ALUSrcA       = 2'd0;
      bus.ALUSrcB       = 3'd0;
      bus.ALUOp         = 3'd0;
      bus.PCSource      = 2'd0;
      bus.MemToReg      = 3'd0;
      case (state_q)
         S_RST: begin
            bus.RegDst   = 3'd3;
            bus.MemToReg = 3'd7;
            bus.RegWrite = 1'b1;
         end
         S_FETCH: begin
            bus.ALUSrcB = 3'd1;
            bus.ALUOp   = 3'd1;
            bus.PCWrite = 1'b1;
         end
         S_IRLD: bus.IRWrite = 1'b1;
         S_DECODE: begin
            bus.WriteA      = 1'b1;
            bus.WriteB      = 1'b1;
            bus.ALUSrcB     = 3'd3;
            bus.ALUOp       = 3'd1;
            bus.WriteALUOut = 1'b1;
         end
         S_ADD, S_AND, S_SUB, S_ADDI: begin
            bus.ALUSrcA     = 2'd1;
            bus.WriteALUOut = 1'b1;
            bus.ALUOp       = (state_q == S_AND) ? 3'd3 : (state_q == S_SUB) ? 3'd2 : 3'd1;
            bus.ALUSrcB     = (state_q == S_ADDI) ? 3'd2 : 3'd0;
         end
         S_WRRD: begin
            bus.RegDst   = 3'd1;
            bus.RegWrite = 1'b1;
         end
         S_WRRT: bus.RegWrite = 1'b1;
         S_EXC: begin
            bus.ALUSrcB       = 3'd1;
            bus.ALUOp         = 3'd2;
            bus.EPCWrite      = 1'b1;
            bus.SrcAddressMem = vec;
         end
         S_EWAIT: bus.SrcAddressMem = vec;
         S_ELD: begin
            bus.SrcAddressMem = vec;
            bus.WriteMDR      = 1'b1;
         end
         S_EJMP: begin
            bus.PCSource = 2'd1;
            bus.PCWrite  = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.ExcCause = cause_q;
   assign bus.StateOut = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized bench for multicycle_ctrl against a state-sequence reference model
module tb_multicycle_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = '0;
   logic [5:0] func = '0;
   logic       ovf = 1'b0;
   logic       sel = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   int mw = 4;
   bit oe = 1'b1;
   int cause_m = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if bus_a ();
   multicycle_ctrl_if bus_b ();

   multicycle_ctrl #(.MEM_WAIT(4), .OVF_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   multicycle_ctrl #(.MEM_WAIT(1), .OVF_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   assign bus_a.OpCode = op;
   assign bus_a.Func = func;
   assign bus_a.Overflow = ovf;
   assign bus_b.OpCode = op;
   assign bus_b.Func = func;
   assign bus_b.Overflow = ovf;

   wire [33:0] obs_a = {bus_a.SrcAddressMem, bus_a.MemOp, bus_a.WriteMDR, bus_a.IRWrite,
                        bus_a.RegWrite, bus_a.WriteA, bus_a.WriteB, bus_a.WriteALUOut,
                        bus_a.EPCWrite, bus_a.PCWrite, bus_a.RegDst, bus_a.ALUSrcA,
                        bus_a.ALUSrcB, bus_a.ALUOp, bus_a.PCSource, bus_a.MemToReg,
                        bus_a.ExcCause, bus_a.StateOut};
   wire [33:0] obs_b = {bus_b.SrcAddressMem, bus_b.MemOp, bus_b.WriteMDR, bus_b.IRWrite,
                        bus_b.RegWrite, bus_b.WriteA, bus_b.WriteB, bus_b.WriteALUOut,
                        bus_b.EPCWrite, bus_b.PCWrite, bus_b.RegDst, bus_b.ALUSrcA,
                        bus_b.ALUSrcB, bus_b.ALUOp, bus_b.PCSource, bus_b.MemToReg,
                        bus_b.ExcCause, bus_b.StateOut};
   wire [33:0] obs = sel ? obs_b : obs_a;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Control word expected in each state, straight from the state/output table
   function automatic logic [33:0] exp_out(input int st, input int c);
      logic [2:0] sam = 0, rdst = 0, srcb = 0, aop = 0, mtr = 0;
      logic       wmdr = 0, irw = 0, rw = 0, wa = 0, wb = 0, wao = 0, epcw = 0, pcw = 0;
      logic [1:0] srca = 0, pcs = 0;
      logic [2:0] vec;
      vec = (c == 2) ? 3'd4 : 3'd3;
      case (st)
         0:  begin rdst = 3; mtr = 7; rw = 1; end
         1:  begin srcb = 1; aop = 1; pcw = 1; end
         3:  irw = 1;
         4:  begin wa = 1; wb = 1; srcb = 3; aop = 1; wao = 1; end
         5:  begin srca = 1; aop = 1; wao = 1; end
         6:  begin srca = 1; aop = 3; wao = 1; end
         7:  begin srca = 1; aop = 2; wao = 1; end
         8:  begin srca = 1; srcb = 2; aop = 1; wao = 1; end
         9:  begin rdst = 1; rw = 1; end
         10: rw = 1;
         11: begin srcb = 1; aop = 2; epcw = 1; sam = vec; end
         12: sam = vec;
         13: begin sam = vec; wmdr = 1; end
         14: begin pcs = 1; pcw = 1; end
         default: ;
      endcase
      return {sam, 1'b0, wmdr, irw, rw, wa, wb, wao, epcw, pcw, rdst, srca, srcb, aop,
              pcs, mtr, 2'(c), 4'(st)};
   endfunction

   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00 && f == 6'h20) return 5;
      if (o == 6'h00 && f == 6'h24) return 6;
      if (o == 6'h00 && f == 6'h22) return 7;
      if (o == 6'h08) return 8;
      return 11;
   endfunction

   // Starts at a falling edge with the DUT in FETCH; ends the same way at the next FETCH
   task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                            input logic v, input int abort_st, output bit aborted);
      int seq[$];
      int ex, c, st;
      bit trap;
      op = o; func = f; ovf = v;
      c = cause_m;
      seq.push_back(1 | (c << 4));
      repeat (mw) seq.push_back(2 | (c << 4));
      seq.push_back(3 | (c << 4));
      seq.push_back(4 | (c << 4));
      ex = classify(o, f);
      trap = 0;
      if (ex == 11) begin
         c = 1;
         trap = 1;
      end else begin
         seq.push_back(ex | (c << 4));
         if ((ex == 5 || ex == 7 || ex == 8) && v && oe) begin
            c = 2;
            trap = 1;
         end else begin
            seq.push_back(((ex == 8) ? 10 : 9) | (c << 4));
         end
      end
      if (trap) begin
         seq.push_back(11 | (c << 4));
         repeat (mw) seq.push_back(12 | (c << 4));
         seq.push_back(13 | (c << 4));
         seq.push_back(14 | (c << 4));
      end
      aborted = 0;
      foreach (seq[i]) begin
         st = seq[i] & 15;
         check($sformatf("%s i%0d s%0d", nm, i, st), obs, exp_out(st, seq[i] >> 4));
         if (st == abort_st) begin
            aborted = 1;
            return;
         end
         @(posedge clk);
         @(negedge clk);
      end
      cause_m = c;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b0;
      #1 check("rst_async", obs, exp_out(0, 0));
      repeat (cycles) begin
         @(negedge clk);
         check("rst_hold", obs, exp_out(0, 0));
      end
      reset = 1'b1;
      cause_m = 0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_instr(output logic [5:0] o, output logic [5:0] f);
      o = 6'($urandom_range(0, 63));
      f = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 4))
         0: begin o = 6'h00; f = 6'h20; end
         1: begin o = 6'h00; f = 6'h24; end
         2: begin o = 6'h00; f = 6'h22; end
         3: o = 6'h08;
         default: ;
      endcase
   endtask

   initial begin
      bit ab;
      logic [5:0] ro, rf;

      sel = 0; mw = 4; oe = 1;
      do_reset(3);
      run_instr("add", 6'h00, 6'h20, 1'b0, -1, ab);
      run_instr("addi_trap", 6'h08, 6'h15, 1'b1, -1, ab);
      run_instr("bad_op", 6'h3F, 6'h00, 1'b0, -1, ab);
      run_instr("add_keep", 6'h00, 6'h20, 1'b0, -1, ab);
      run_instr("and_ovf", 6'h00, 6'h24, 1'b1, -1, ab);
      run_instr("sub_trap", 6'h00, 6'h22, 1'b1, -1, ab);
      run_instr("bad_abort", 6'h3F, 6'h00, 1'b0, 12, ab);
      check("abort_hit", 32'(ab), 32'd1);
      do_reset(2);
      for (int i = 0; i < 30; i++) begin
         rand_instr(ro, rf);
         run_instr("rnd_a", ro, rf, 1'($urandom_range(0, 1)), -1, ab);
      end

      sel = 1; mw = 1; oe = 0;
      do_reset(3);
      run_instr("b_addi", 6'h08, 6'h01, 1'b1, -1, ab);
      run_instr("b_sub", 6'h00, 6'h22, 1'b1, -1, ab);
      run_instr("b_bad", 6'h3F, 6'h3F, 1'b0, -1, ab);
      run_instr("b_add_keep", 6'h00, 6'h20, 1'b1, -1, ab);
      for (int i = 0; i < 30; i++) begin
         rand_instr(ro, rf);
         run_instr("rnd_b", ro, rf, 1'($urandom_range(0, 1)), -1, ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
